// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: widths, ALU op encodings
// and the ID/EX control bundle.
package pipeline_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 16;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_XOR = 4'd5,
    ALU_NOR = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_LUI = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic       escreve_reg;
    logic       le_mem;
    logic       escreve_mem;
    logic       mem_para_reg;
    logic       alu_src;
    logic [3:0] alu_op;
  } id_ex_ctrl_t;

  localparam int CTRL_W = $bits(id_ex_ctrl_t);

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard equation: a valid load in EX whose destination is read by
// the valid instruction currently in ID.
module load_use_detect
  import pipeline_pkg::*;
#(
  parameter int REG_W = pipeline_pkg::REG_W
)(
  input  logic             ex_valido,
  input  logic             ex_le_mem,
  input  logic [REG_W-1:0] ex_rd_dest,
  input  logic             id_valido,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_usa_rt,
  output logic             hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rd_dest == id_rs);
  assign rt_hit = id_usa_rt & (ex_rd_dest == id_rt);

  // A load targeting $0 produces nothing a consumer could wait for.
  assign hazard = ex_valido & ex_le_mem & (ex_rd_dest != REG_W'(REG_ZERO)) &
                  id_valido & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and saturating
// stall/flush event counters.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int REG_W  = pipeline_pkg::REG_W,
  parameter int CNT_W  = pipeline_pkg::CNT_W
)(
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_W-1:0]  IF_ID_rs,
  input  logic [REG_W-1:0]  IF_ID_rt,
  input  logic [REG_W-1:0]  IF_ID_rd,
  input  logic              IF_ID_usa_rt,
  input  logic              IF_ID_valido,
  input  logic [DATA_W-1:0] ID_dadoA,
  input  logic [DATA_W-1:0] ID_dadoB,
  input  logic [DATA_W-1:0] ID_imediato,
  input  logic [DATA_W-1:0] ID_pc4,
  input  logic              ID_EscreveReg,
  input  logic              ID_LeMem,
  input  logic              ID_EscreveMem,
  input  logic              ID_MemParaReg,
  input  logic              ID_ALUSrc,
  input  logic              ID_RegDst,
  input  logic [3:0]        ID_ALUOp,
  input  logic              EX_flush,
  output logic [REG_W-1:0]  ID_EX_rs,
  output logic [REG_W-1:0]  ID_EX_rt,
  output logic [REG_W-1:0]  ID_EX_rd_dest,
  output logic [DATA_W-1:0] ID_EX_dadoA,
  output logic [DATA_W-1:0] ID_EX_dadoB,
  output logic [DATA_W-1:0] ID_EX_imediato,
  output logic [DATA_W-1:0] ID_EX_pc4,
  output logic              ID_EX_EscreveReg,
  output logic              ID_EX_LeMem,
  output logic              ID_EX_EscreveMem,
  output logic              ID_EX_MemParaReg,
  output logic              ID_EX_ALUSrc,
  output logic [3:0]        ID_EX_ALUOp,
  output logic              ID_EX_valido,
  output logic              PC_escreve,
  output logic              IF_ID_escreve,
  output logic              stall,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_flush
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic        hazard;
  logic        bubble;
  id_ex_ctrl_t ctrl_d;
  id_ex_ctrl_t ctrl_q;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .ex_valido  (ID_EX_valido),
    .ex_le_mem  (ID_EX_LeMem),
    .ex_rd_dest (ID_EX_rd_dest),
    .id_valido  (IF_ID_valido),
    .id_rs      (IF_ID_rs),
    .id_rt      (IF_ID_rt),
    .id_usa_rt  (IF_ID_usa_rt),
    .hazard     (hazard)
  );

  // A flush already kills the consumer, so it never also needs a stall.
  assign stall         = hazard & ~EX_flush;
  assign PC_escreve    = ~stall;
  assign IF_ID_escreve = ~stall;
  assign bubble        = EX_flush | stall;

  // Side-effecting controls are tied to valido so an empty slot can never
  // write the register file or memory, whatever decode presents.
  always_comb begin
    ctrl_d              = '0;
    ctrl_d.escreve_reg  = ID_EscreveReg & IF_ID_valido;
    ctrl_d.le_mem       = ID_LeMem & IF_ID_valido;
    ctrl_d.escreve_mem  = ID_EscreveMem & IF_ID_valido;
    ctrl_d.mem_para_reg = ID_MemParaReg;
    ctrl_d.alu_src      = ID_ALUSrc;
    ctrl_d.alu_op       = ID_ALUOp;
  end

  always_ff @(posedge clock) begin
    if (!reset || bubble) begin
      ID_EX_rs       <= '0;
      ID_EX_rt       <= '0;
      ID_EX_rd_dest  <= '0;
      ID_EX_dadoA    <= '0;
      ID_EX_dadoB    <= '0;
      ID_EX_imediato <= '0;
      ID_EX_pc4      <= '0;
      ctrl_q         <= '0;
      ID_EX_valido   <= 1'b0;
    end else begin
      ID_EX_rs       <= IF_ID_rs;
      ID_EX_rt       <= IF_ID_rt;
      ID_EX_rd_dest  <= ID_RegDst ? IF_ID_rd : IF_ID_rt;
      ID_EX_dadoA    <= ID_dadoA;
      ID_EX_dadoB    <= ID_dadoB;
      ID_EX_imediato <= ID_imediato;
      ID_EX_pc4      <= ID_pc4;
      ctrl_q         <= ctrl_d;
      ID_EX_valido   <= IF_ID_valido;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else begin
      if (stall && cnt_stall != CNT_MAX) cnt_stall <= cnt_stall + CNT_W'(1);
      if (EX_flush && cnt_flush != CNT_MAX) cnt_flush <= cnt_flush + CNT_W'(1);
    end
  end

  assign ID_EX_EscreveReg = ctrl_q.escreve_reg;
  assign ID_EX_LeMem      = ctrl_q.le_mem;
  assign ID_EX_EscreveMem = ctrl_q.escreve_mem;
  assign ID_EX_MemParaReg = ctrl_q.mem_para_reg;
  assign ID_EX_ALUSrc     = ctrl_q.alu_src;
  assign ID_EX_ALUOp      = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: hazard vector table, hand-written multi-cycle
// sequences and random stimulus against an instruction-level model.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam int CMAX = 65535;
  localparam int VW   = 188;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  IF_ID_rs, IF_ID_rt, IF_ID_rd;
  logic        IF_ID_usa_rt, IF_ID_valido;
  logic [31:0] ID_dadoA, ID_dadoB, ID_imediato, ID_pc4;
  logic        ID_EscreveReg, ID_LeMem, ID_EscreveMem, ID_MemParaReg, ID_ALUSrc, ID_RegDst;
  logic [3:0]  ID_ALUOp;
  logic        EX_flush;
  logic [4:0]  ID_EX_rs, ID_EX_rt, ID_EX_rd_dest;
  logic [31:0] ID_EX_dadoA, ID_EX_dadoB, ID_EX_imediato, ID_EX_pc4;
  logic        ID_EX_EscreveReg, ID_EX_LeMem, ID_EX_EscreveMem, ID_EX_MemParaReg, ID_EX_ALUSrc;
  logic [3:0]  ID_EX_ALUOp;
  logic        ID_EX_valido, PC_escreve, IF_ID_escreve, stall;
  logic [15:0] cnt_stall, cnt_flush;

  always #5 clock = ~clock;

  id_ex_stage dut (
    .clock(clock), .reset(reset),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_rd(IF_ID_rd),
    .IF_ID_usa_rt(IF_ID_usa_rt), .IF_ID_valido(IF_ID_valido),
    .ID_dadoA(ID_dadoA), .ID_dadoB(ID_dadoB), .ID_imediato(ID_imediato), .ID_pc4(ID_pc4),
    .ID_EscreveReg(ID_EscreveReg), .ID_LeMem(ID_LeMem), .ID_EscreveMem(ID_EscreveMem),
    .ID_MemParaReg(ID_MemParaReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
    .ID_ALUOp(ID_ALUOp), .EX_flush(EX_flush),
    .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt), .ID_EX_rd_dest(ID_EX_rd_dest),
    .ID_EX_dadoA(ID_EX_dadoA), .ID_EX_dadoB(ID_EX_dadoB),
    .ID_EX_imediato(ID_EX_imediato), .ID_EX_pc4(ID_EX_pc4),
    .ID_EX_EscreveReg(ID_EX_EscreveReg), .ID_EX_LeMem(ID_EX_LeMem),
    .ID_EX_EscreveMem(ID_EX_EscreveMem), .ID_EX_MemParaReg(ID_EX_MemParaReg),
    .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_valido(ID_EX_valido),
    .PC_escreve(PC_escreve), .IF_ID_escreve(IF_ID_escreve), .stall(stall),
    .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
  );

  // Model: the instruction currently occupying EX, plus event tallies.
  typedef struct {
    logic [4:0]  rs, rt, dest;
    logic [31:0] a, b, imm, pc4;
    logic        er, lm, em, mr, as, v;
    logic [3:0]  op;
    int          cs, cf;
  } model_t;

  typedef struct {
    logic [4:0] ex_dest;
    logic       ex_load, ex_valid;
    logic [4:0] rs, rt;
    logic       usa, valid, flush;
    logic       exp_stall;
  } vec_t;

  model_t m;
  vec_t   vecs[9];
  int     errors = 0;
  int     checks = 0;

  function automatic model_t empty_model();
    model_t e;
    e.rs = 0; e.rt = 0; e.dest = 0; e.a = 0; e.b = 0; e.imm = 0; e.pc4 = 0;
    e.er = 0; e.lm = 0; e.em = 0; e.mr = 0; e.as = 0; e.v = 0; e.op = 0;
    e.cs = 0; e.cf = 0;
    return e;
  endfunction

  // Consumer in ID needs the register a real load in EX is still fetching.
  function automatic logic model_stall();
    logic needs;
    needs = (m.dest == IF_ID_rs) || (IF_ID_usa_rt && m.dest == IF_ID_rt);
    return m.v && m.lm && (m.dest != 5'd0) && IF_ID_valido && needs && !EX_flush;
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name);
    logic st;
    logic [VW-1:0] exp, act;
    st  = model_stall();
    exp = {m.rs, m.rt, m.dest, m.a, m.b, m.imm, m.pc4, m.er, m.lm, m.em, m.mr, m.as,
           m.op, m.v, 16'(m.cs), 16'(m.cf), st, ~st, ~st};
    act = {ID_EX_rs, ID_EX_rt, ID_EX_rd_dest, ID_EX_dadoA, ID_EX_dadoB, ID_EX_imediato,
           ID_EX_pc4, ID_EX_EscreveReg, ID_EX_LeMem, ID_EX_EscreveMem, ID_EX_MemParaReg,
           ID_EX_ALUSrc, ID_EX_ALUOp, ID_EX_valido, cnt_stall, cnt_flush, stall,
           PC_escreve, IF_ID_escreve};
    check(name, act, exp);
  endtask

  // Advance one clock, moving the model by the same instruction-level rules.
  task automatic tick();
    model_t n, e;
    logic st;
    st = model_stall();
    n  = m;
    if (!reset) begin
      n = empty_model();
    end else begin
      if (EX_flush && n.cf < CMAX) n.cf++;
      if (st && n.cs < CMAX) n.cs++;
      if (EX_flush || st) begin
        e = empty_model(); e.cs = n.cs; e.cf = n.cf; n = e;
      end else begin
        n.rs = IF_ID_rs; n.rt = IF_ID_rt;
        n.dest = ID_RegDst ? IF_ID_rd : IF_ID_rt;
        n.a = ID_dadoA; n.b = ID_dadoB; n.imm = ID_imediato; n.pc4 = ID_pc4;
        n.v = IF_ID_valido;
        n.er = ID_EscreveReg && IF_ID_valido;
        n.lm = ID_LeMem && IF_ID_valido;
        n.em = ID_EscreveMem && IF_ID_valido;
        n.mr = ID_MemParaReg; n.as = ID_ALUSrc; n.op = ID_ALUOp;
      end
    end
    @(posedge clock);
    #1;
    m = n;
  endtask

  task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic usa, input logic valid, input logic wr,
                             input logic ld, input logic regdst);
    IF_ID_rs = rs; IF_ID_rt = rt; IF_ID_rd = rd;
    IF_ID_usa_rt = usa; IF_ID_valido = valid;
    ID_dadoA = $urandom; ID_dadoB = $urandom; ID_imediato = $urandom; ID_pc4 = $urandom;
    ID_EscreveReg = wr; ID_LeMem = ld; ID_EscreveMem = 1'b0; ID_MemParaReg = ld;
    ID_ALUSrc = ld; ID_RegDst = regdst; ID_ALUOp = 4'($urandom_range(0, 9));
  endtask

  task automatic rand_inputs();
    IF_ID_rs = 5'($urandom_range(0, 3));
    IF_ID_rt = 5'($urandom_range(0, 3));
    IF_ID_rd = 5'($urandom_range(0, 3));
    IF_ID_usa_rt = 1'($urandom); IF_ID_valido = ($urandom_range(0, 4) != 0);
    ID_dadoA = $urandom; ID_dadoB = $urandom; ID_imediato = $urandom; ID_pc4 = $urandom;
    ID_EscreveReg = 1'($urandom); ID_LeMem = 1'($urandom); ID_EscreveMem = 1'($urandom);
    ID_MemParaReg = 1'($urandom); ID_ALUSrc = 1'($urandom); ID_RegDst = 1'($urandom);
    ID_ALUOp = 4'($urandom);
    EX_flush = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    // ex_dest, ex_load, ex_valid, rs, rt, usa, valid, flush, exp_stall
    vecs[0] = '{5'd8,  1, 1, 5'd8,  5'd11, 1, 1, 0, 1}; // lw $8; add $10,$8,$11
    vecs[1] = '{5'd8,  1, 1, 5'd12, 5'd8,  0, 1, 0, 0}; // addi ignores rt
    vecs[2] = '{5'd0,  1, 1, 5'd0,  5'd0,  1, 1, 0, 0}; // load to $0
    vecs[3] = '{5'd8,  1, 1, 5'd9,  5'd8,  1, 1, 0, 1}; // hit on rt
    vecs[4] = '{5'd8,  0, 1, 5'd8,  5'd8,  1, 1, 0, 0}; // producer not a load
    vecs[5] = '{5'd8,  1, 0, 5'd8,  5'd8,  1, 1, 0, 0}; // producer is a bubble
    vecs[6] = '{5'd8,  1, 1, 5'd8,  5'd8,  1, 0, 0, 0}; // consumer not valid
    vecs[7] = '{5'd8,  1, 1, 5'd8,  5'd8,  1, 1, 1, 0}; // flush wins
    vecs[8] = '{5'd31, 1, 1, 5'd0,  5'd31, 1, 1, 0, 1}; // highest register

    m = empty_model();
    reset = 1'b0;
    rand_inputs(); tick();
    rand_inputs(); tick();
    rand_inputs(); #1;
    check_all("reset_state");
    check("reset_ctl", VW'({PC_escreve, IF_ID_escreve, stall, ID_EX_valido, cnt_stall, cnt_flush}),
          VW'({4'b1100, 32'd0}));

    reset = 1'b1;
    foreach (vecs[i]) begin
      EX_flush = 1'b1; tick();
      EX_flush = 1'b0;
      drive_instr(5'd9, vecs[i].ex_dest, 5'd0, 1'b0, vecs[i].ex_valid, 1'b1, vecs[i].ex_load, 1'b0);
      tick();
      drive_instr(vecs[i].rs, vecs[i].rt, 5'd10, vecs[i].usa, vecs[i].valid, 1'b1, 1'b0, 1'b1);
      EX_flush = vecs[i].flush;
      #1;
      check($sformatf("vec%0d_stall", i), VW'({stall, PC_escreve, IF_ID_escreve}),
            VW'({vecs[i].exp_stall, ~vecs[i].exp_stall, ~vecs[i].exp_stall}));
      check_all($sformatf("vec%0d_state", i));
      tick();
      if (vecs[i].exp_stall) begin
        EX_flush = 1'b0; #1;
        check($sformatf("vec%0d_restall", i), VW'({stall, ID_EX_valido}), VW'(2'b00));
        tick();
        check($sformatf("vec%0d_enter", i), VW'({ID_EX_valido, ID_EX_rs}), VW'({1'b1, vecs[i].rs}));
      end
      check_all($sformatf("vec%0d_after", i));
    end

    // add $3,$1,$2 with known data
    EX_flush = 1'b1; tick(); EX_flush = 1'b0;
    drive_instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    ID_dadoA = 32'h1111_0001; ID_dadoB = 32'h2222_0002;
    ID_imediato = 32'hFFFF_8003; ID_pc4 = 32'h0040_0104; ID_ALUOp = ALU_ADD;
    tick();
    check("add_dest", VW'(ID_EX_rd_dest), VW'(5'd3));
    check("add_data", VW'({ID_EX_dadoA, ID_EX_dadoB, ID_EX_imediato, ID_EX_pc4}),
          VW'({32'h1111_0001, 32'h2222_0002, 32'hFFFF_8003, 32'h0040_0104}));
    check_all("add_state");

    // load-use with simultaneous flush from a clean reset
    reset = 1'b0; tick(); reset = 1'b1;
    drive_instr(5'd9, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive_instr(5'd8, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    EX_flush = 1'b1; #1;
    check("flush_hz_stall", VW'({stall, PC_escreve}), VW'(2'b01));
    tick();
    check("flush_hz_cnt", VW'({cnt_stall, cnt_flush, ID_EX_valido}), VW'({16'd0, 16'd1, 1'b0}));

    // reset asserted while a stall is active
    EX_flush = 1'b0;
    drive_instr(5'd9, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive_instr(5'd8, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); #1;
    check("midstall_pre", VW'(stall), VW'(1'b1));
    reset = 1'b0; tick();
    check("midstall_post", VW'({stall, PC_escreve, IF_ID_escreve, ID_EX_valido, cnt_stall, cnt_flush}),
          VW'({4'b0110, 32'd0}));
    check_all("midstall_state");
    reset = 1'b1;

    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      reset = ($urandom_range(0, 49) != 0);
      #1;
      check_all($sformatf("rand%0d", c));
      tick();
    end

    reset = 1'b1;
    rand_inputs();
    EX_flush = 1'b1;
    for (int c = 0; c < CMAX + 1 + 5; c++) tick();
    check("sat_flush", VW'(cnt_flush), VW'(16'hFFFF));
    check_all("sat_state");
    tick();
    check("sat_hold", VW'(cnt_flush), VW'(16'hFFFF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. It sits between decode and execute: it latches the decoded operands, register numbers and control bits from IF/ID and feeds the ID_EX_rs/ID_EX_rt/destination fields consumed by the forwarding unit and the EX stage. It also stalls PC and IF/ID for one cycle on a load-use dependency and inserts a bubble, and squashes the stage on a taken-branch flush. Two saturating event counters (stalls, flushes) support performance debug.

## Interface
- DATA_W, 32, operand/immediate/PC width
- REG_W, 5, register-number width
- CNT_W, 16, event counter width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- IF_ID_rs, IF_ID_rt, IF_ID_rd  in  REG_W  register fields of decoding instruction
- IF_ID_usa_rt  in  1  instruction reads rt as a source (R-type, beq, sw)
- IF_ID_valido  in  1  IF/ID holds a real instruction
- ID_dadoA, ID_dadoB, ID_imediato, ID_pc4  in  DATA_W  register-file reads, sign-extended immediate, PC+4
- ID_EscreveReg, ID_LeMem, ID_EscreveMem, ID_MemParaReg, ID_ALUSrc, ID_RegDst  in  1  decoded control
- ID_ALUOp  in  4  ALU operation
- EX_flush  in  1  taken branch/jump resolved in EX: squash this stage
- ID_EX_rs, ID_EX_rt, ID_EX_rd_dest  out  REG_W  registered source numbers and selected destination (RegDst ? rd : rt)
- ID_EX_dadoA, ID_EX_dadoB, ID_EX_imediato, ID_EX_pc4  out  DATA_W  registered data
- ID_EX_EscreveReg, ID_EX_LeMem, ID_EX_EscreveMem, ID_EX_MemParaReg, ID_EX_ALUSrc  out  1  registered control
- ID_EX_ALUOp  out  4  registered ALU op
- ID_EX_valido  out  1  stage holds a real instruction
- PC_escreve, IF_ID_escreve  out  1  write enables to PC and IF/ID; 0 during stall
- stall  out  1  load-use stall asserted this cycle
- cnt_stall, cnt_flush  out  CNT_W  saturating event counts

## Operation
- Hazard (combinational, from current ID/EX regs and IF/ID inputs): hazard = ID_EX_valido & ID_EX_LeMem & (ID_EX_rd_dest != 0) & IF_ID_valido & ((ID_EX_rd_dest == IF_ID_rs) | (IF_ID_usa_rt & ID_EX_rd_dest == IF_ID_rt)).
- stall = hazard & ~EX_flush. PC_escreve = IF_ID_escreve = ~stall.
- Next-state priority at each edge: reset > EX_flush > stall > normal load.
  - reset low: all outputs cleared (bubble), counters 0.
  - EX_flush: load bubble (all control bits, valido, register numbers and data = 0).
  - stall: load bubble; IF/ID and PC hold externally, so the dependent instruction is re-presented next cycle.
  - normal: load all ID_* inputs; ID_EX_valido <= IF_ID_valido; ID_EX_rd_dest <= ID_RegDst ? IF_ID_rd : IF_ID_rt.
- Bubble invariant: ID_EX_valido = 0 implies EscreveReg, LeMem, EscreveMem all 0.
- A bubble never triggers a stall (valido gating); a load writing $0 never stalls.
- cnt_stall increments on each cycle stall = 1; cnt_flush on each cycle EX_flush = 1; both saturate at all-ones, no wrap.

## Timing
- Register latency 1 cycle: inputs at edge N appear on ID_EX_* after edge N.
- stall, PC_escreve, IF_ID_escreve valid in the same cycle as the hazard; stall lasts exactly 1 cycle per load-use pair (after the bubble, the load has left ID/EX).
- Flush and hazard in same cycle: flush wins, stall = 0, cnt_stall unchanged, cnt_flush +1.
- Reset mid-stall: next cycle stall = 0, PC_escreve = 1, all outputs 0.
- Reset values: every output 0 except PC_escreve = 1, IF_ID_escreve = 1.

## Structure
- Shared package pipeline_pkg: REG_W, DATA_W, ALUOp encodings, REG_ZERO constant, ID/EX control bundle width.
- One sub-module: load_use_detect (pure combinational hazard equation); register, priority mux and counters live in id_ex_stage.

## Test plan
- Reset low 2 cycles with random inputs -> all ID_EX_* = 0, PC_escreve = IF_ID_escreve = 1, counters 0.
- lw $8,0($9) then add $10,$8,$11 -> one cycle stall = 1, PC_escreve = 0, bubble in ID/EX (valido = 0), add enters next cycle; cnt_stall = 1.
- lw $8 then addi $10,$12,4 with IF_ID_rt = 8, IF_ID_usa_rt = 0 -> no stall; lw $0 then add $1,$0,$0 -> no stall.
- lw $8 then add $9,$8,$8 with EX_flush = 1 same cycle -> stall = 0, bubble loaded, cnt_flush = 1, cnt_stall = 0.
- add $3,$1,$2 with RegDst = 1, rd = 3 -> ID_EX_rd_dest = 3 one cycle later, all data fields match inputs.
- Force 2^CNT_W + 5 flushes -> cnt_flush holds at 0xFFFF, no wrap.
